// File: rtl/mem_sequencer.sv
// Multi-cycle memory sequencer: owns the PC, fetches over readM/inputReady, performs at most
// one load (readM/inputReady) or store (writeM/ackOutput), then pulses commit to retire.
module mem_sequencer #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] next_pc,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 commit,
  output logic                 bus_error,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic [2:0]           dbg_state
);

  // Handshake: a request (readM or writeM) is held with a stable address until a clock edge
  // on which the matching response (inputReady for reads, ackOutput for writes) is high; that
  // edge completes the transfer. Responses outside the matching request state are ignored.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam int           CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [WORD_SIZE-1:0] daddr_q, daddr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [CW-1:0]        wait_q, wait_d;

  logic [CW-1:0] wait_inc;
  logic          timeout_hit;

  // Saturating wait counter; the error fires when the count of absent-response cycles
  // would reach TIMEOUT.
  assign wait_inc    = (wait_q == {CW{1'b1}}) ? wait_q : wait_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (wait_inc == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      rdata_q <= '0;
      daddr_q <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      daddr_q <= daddr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    daddr_d = daddr_q;
    wdata_d = wdata_q;
    wait_d  = '0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (inputReady) begin
          instr_d = data;
          state_d = S_EXEC;
        end else begin
          wait_d = wait_inc;
          if (timeout_hit) state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        daddr_d = d_addr;
        wdata_d = d_wdata;
        if (!d_req)    state_d = S_WB;
        else if (d_we) state_d = S_MEM_WR;
        else           state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (inputReady) begin
          rdata_d = data;
          state_d = S_WB;
        end else begin
          wait_d = wait_inc;
          if (timeout_hit) state_d = S_ERROR;
        end
      end
      S_MEM_WR: begin
        if (ackOutput) begin
          state_d = S_WB;
        end else begin
          wait_d = wait_inc;
          if (timeout_hit) state_d = S_ERROR;
        end
      end
      S_WB: begin
        pc_d    = next_pc;
        state_d = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so an asynchronous reset drops them immediately.
  assign readM       = (state_q == S_FETCH) || (state_q == S_MEM_RD);
  assign writeM      = (state_q == S_MEM_WR);
  assign address     = (state_q == S_FETCH) ? pc_q :
                       ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) ? daddr_q : '0;
  assign data        = (state_q == S_MEM_WR) ? wdata_q : {WORD_SIZE{1'bz}};
  assign instr_valid = (state_q == S_EXEC);
  assign commit      = (state_q == S_WB);
  assign bus_error   = (state_q == S_ERROR);
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign d_rdata     = rdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: random instruction stream against a transaction-level model, with a
// memory/datapath agent, a commit scoreboard, timeout and mid-transaction reset scenarios.
`timescale 1ns/1ps
module tb_mem_sequencer;
  localparam int           W      = 16;
  localparam logic [W-1:0] RST_PC = 16'h0010;
  localparam int           TMO    = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] next_pc = '0;
  logic         d_req = 1'b0, d_we = 1'b0;
  logic [W-1:0] d_addr = '0, d_wdata = '0;
  logic [W-1:0] pc, instr, d_rdata, address;
  logic         instr_valid, commit, bus_error, readM, writeM;
  logic         inputReady = 1'b0, ackOutput = 1'b0;
  logic [2:0]   dbg_state;
  tri1  [W-1:0] data_w;
  logic         mem_drv = 1'b0;
  logic [W-1:0] mem_data = '0;

  assign data_w = mem_drv ? mem_data : {W{1'bz}};

  mem_sequencer #(.WORD_SIZE(W), .RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .d_rdata(d_rdata), .commit(commit), .bus_error(bus_error), .readM(readM),
    .writeM(writeM), .address(address), .data(data_w), .inputReady(inputReady),
    .ackOutput(ackOutput), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [W-1:0] pc, instr, daddr, wdata, rdata, next_pc;
    logic         req, we;
    int           fwait, dwait;
  } txn_t;
  typedef struct {
    logic [W-1:0] pc, instr, rdata;
    int           lat;
  } exp_t;

  txn_t txn_q[$];
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic agent_en = 1'b0;
  logic [W-1:0] pc_m, rdata_m;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each instruction costs fetch + exec + writeback plus one cycle per wait,
  // and one more bus cycle (plus its waits) when it accesses data.
  task automatic add_txn(input logic [W-1:0] ins, input logic req, input logic we,
                         input logic [W-1:0] daddr, input logic [W-1:0] wdata,
                         input logic [W-1:0] rdata, input logic [W-1:0] npc,
                         input int fwait, input int dwait);
    txn_t t;
    exp_t e;
    t.pc = pc_m; t.instr = ins; t.req = req; t.we = we; t.daddr = daddr;
    t.wdata = wdata; t.rdata = rdata; t.next_pc = npc; t.fwait = fwait; t.dwait = dwait;
    txn_q.push_back(t);
    if (req && !we) rdata_m = rdata;
    e.pc = pc_m; e.instr = ins; e.rdata = rdata_m;
    e.lat = 3 + fwait + (req ? 1 + dwait : 0);
    exp_q.push_back(e);
    pc_m = npc;
  endtask

  task automatic add_random();
    logic req, we;
    int   fw, dw;
    req = ($urandom_range(0, 2) != 0);
    we  = 1'($urandom_range(0, 1));
    fw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO-1)) : int'($urandom_range(0, 2));
    dw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO-1)) : int'($urandom_range(0, 2));
    add_txn(W'($urandom), req, we, W'($urandom), W'($urandom_range(0, 16'hFFFE)),
            W'($urandom), W'($urandom), fw, dw);
  endtask

  task automatic model_reset();
    txn_q.delete();
    exp_q.delete();
    pc_m    = RST_PC;
    rdata_m = '0;
  endtask

  // ---------------- memory / datapath agent ----------------
  logic fetched = 1'b0;
  int   cnt = 0;
  always @(negedge clk) begin : agent
    txn_t t;
    if (reset || !agent_en) begin
      fetched = 1'b0; cnt = 0; mem_drv = 1'b0; inputReady = 1'b0; ackOutput = 1'b0;
    end else begin
      if (!mem_drv && !writeM) chk("data_released", data_w, '1);
      if (!readM && !writeM)   chk("address_idle", address, '0);
      chk("no_bus_error", bus_error, '0);
      mem_drv = 1'b0; inputReady = 1'b0; ackOutput = 1'b0;
      d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
      d_addr = W'($urandom); d_wdata = W'($urandom);
      if (txn_q.size() != 0) begin
        t = txn_q[0];
        next_pc = t.next_pc;
        if (instr_valid) begin
          d_req = t.req; d_we = t.we; d_addr = t.daddr; d_wdata = t.wdata;
        end
        if (readM && !fetched) begin
          chk("fetch_addr", address, t.pc);
          if (cnt == t.fwait) begin
            inputReady = 1'b1; mem_drv = 1'b1; mem_data = t.instr; fetched = 1'b1; cnt = 0;
          end else begin
            cnt++; ackOutput = 1'($urandom_range(0, 1));
          end
        end else if (readM) begin
          chk("load_addr", address, t.daddr);
          if (cnt == t.dwait) begin
            inputReady = 1'b1; mem_drv = 1'b1; mem_data = t.rdata; cnt = 0;
          end else begin
            cnt++; ackOutput = 1'($urandom_range(0, 1));
          end
        end else if (writeM) begin
          chk("store_addr", address, t.daddr);
          chk("store_data", data_w, t.wdata);
          if (cnt == t.dwait) begin
            ackOutput = 1'b1; cnt = 0;
          end else begin
            cnt++; inputReady = 1'($urandom_range(0, 1));
          end
        end else begin
          inputReady = ($urandom_range(0, 3) == 0);
          ackOutput  = ($urandom_range(0, 3) == 0);
        end
        if (commit) begin
          void'(txn_q.pop_front());
          fetched = 1'b0; cnt = 0;
        end
      end
    end
  end

  // ---------------- commit monitor ----------------
  int last_cyc = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      last_cyc = 0;
    end else if (commit) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_commit: got commit at pc %h, expected none", pc);
      end else begin
        e = exp_q.pop_front();
        chk("commit_pc", pc, e.pc);
        chk("commit_instr", instr, e.instr);
        chk("commit_rdata", d_rdata, e.rdata);
        chk("commit_latency", W'(cyc - last_cyc), W'(e.lat));
        last_cyc = cyc;
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic drain(input string name);
    for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: got %0d commits pending, expected 0", name, exp_q.size());
    end
  endtask

  initial begin : main
    bit seen;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, '0);
    chk("rst_rdata", d_rdata, '0);
    chk("rst_flags", {instr_valid, commit, bus_error, readM, writeM}, '0);
    chk("rst_address", address, '0);
    chk("rst_data", data_w, '1);

    // Directed corner cases first, then a random stream.
    add_txn(16'h6001, 1'b0, 1'b0, '0, '0, '0, 16'h0001, 0, 0);
    add_txn(16'h7002, 1'b1, 1'b0, 16'h0040, '0, 16'hBEEF, 16'h0002, 0, 2);
    add_txn(16'h8003, 1'b1, 1'b1, 16'h0041, 16'h1234, '0, 16'h0003, 0, 1);
    add_txn(16'h9004, 1'b0, 1'b0, '0, '0, '0, 16'h0004, TMO-1, 0);
    add_txn(16'hA005, 1'b1, 1'b0, 16'h0050, '0, 16'h5A5A, 16'h0005, 1, TMO-1);
    add_txn(16'hB006, 1'b1, 1'b1, 16'h0051, 16'h00FF, '0, 16'h0006, TMO-1, TMO-1);
    for (int i = 0; i < 40; i++) add_random();
    @(negedge clk);
    reset = 1'b0; agent_en = 1'b1;
    drain("drain_random");

    // Reset in the middle of a store.
    @(negedge clk);
    reset = 1'b1; agent_en = 1'b0;
    model_reset();
    add_txn(16'hC007, 1'b0, 1'b0, '0, '0, '0, 16'h0A0A, 0, 0);
    add_txn(16'hD008, 1'b1, 1'b1, 16'h0060, 16'h4321, '0, 16'h0B0B, 0, 6);
    @(negedge clk);
    reset = 1'b0; agent_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = writeM;
    end
    chk("midrst_reached_store", {15'b0, seen}, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_writeM", {15'b0, writeM}, '0);
    chk("midrst_readM", {15'b0, readM}, '0);
    chk("midrst_data", data_w, '1);
    chk("midrst_pc", pc, RST_PC);
    agent_en = 1'b0;
    model_reset();

    // Timeout with memory never answering the fetch.
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= TMO + 21; k++) begin
      @(negedge clk);
      chk("to_readM", {15'b0, readM}, (k <= TMO) ? 16'd1 : 16'd0);
      chk("to_bus_error", {15'b0, bus_error}, (k > TMO) ? 16'd1 : 16'd0);
      if (k <= TMO) chk("to_address", address, RST_PC);
    end

    // Reset recovers and fetching resumes at RESET_PC.
    reset = 1'b1;
    @(negedge clk);
    chk("err_cleared", {15'b0, bus_error}, '0);
    model_reset();
    for (int i = 0; i < 10; i++) add_random();
    reset = 1'b0; agent_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("resume_readM", {15'b0, readM}, 16'd1);
    chk("resume_address", address, RST_PC);
    drain("drain_resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
